// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// master drives operands and out_ready; slave is the divider itself.
interface seq_divider_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] dividend;
    logic signed [DATA_WIDTH-1:0] divisor;
    logic                         out_valid;
    logic                         out_ready;
    logic        [DATA_WIDTH-1:0] quotient;
    logic        [DATA_WIDTH-1:0] remainder;
    logic                         overflow;
    logic                         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one quotient bit per cycle,
// signs and error cases applied in a single fix-up cycle. Fixed latency of DATA_WIDTH+1 edges.
module seq_divider #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int unsigned DW   = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [DW-1:0]   One     = DW'(1);
    localparam logic [DW-1:0]   MaxPos  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   MinNeg  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state_q,   state_d;
    logic [CntW-1:0] cnt_q,     cnt_d;
    logic [DW:0]     rem_q,     rem_d;
    logic [DW-1:0]   acc_q,     acc_d;
    logic [DW-1:0]   dvs_q,     dvs_d;
    logic [DW-1:0]   dvd_q,     dvd_d;
    logic            neg_dvd_q, neg_dvd_d;
    logic            neg_dvs_q, neg_dvs_d;
    logic [DW-1:0]   quo_res_q, quo_res_d;
    logic [DW-1:0]   rem_res_q, rem_res_d;
    logic            ovf_q,     ovf_d;
    logic            dbz_q,     dbz_d;

    logic [DW-1:0] dvd_raw, dvs_raw, dvd_mag, dvs_mag;
    logic [DW:0]   rem_shift, rem_diff;
    logic          q_bit;
    logic          q_neg;
    logic [DW-1:0] q_signed, r_signed;

    always_comb begin
        dvd_raw = bus.dividend;
        dvs_raw = bus.divisor;
        dvd_mag = dvd_raw[DW-1] ? (~dvd_raw + One) : dvd_raw;
        dvs_mag = dvs_raw[DW-1] ? (~dvs_raw + One) : dvs_raw;
    end

    // acc_q starts as the dividend magnitude and fills with quotient bits as it shifts out.
    always_comb begin
        rem_shift = (rem_q << 1) | {{DW{1'b0}}, acc_q[DW-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        q_bit     = ~rem_diff[DW];
        q_neg     = neg_dvd_q ^ neg_dvs_q;
        q_signed  = q_neg ? (~acc_q + One) : acc_q;
        r_signed  = neg_dvd_q ? (~rem_q[DW-1:0] + One) : rem_q[DW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        quo_res_d = quo_res_q;
        rem_res_d = rem_res_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    dvd_d     = dvd_raw;
                    neg_dvd_d = dvd_raw[DW-1];
                    neg_dvs_d = dvs_raw[DW-1];
                    acc_d     = dvd_mag;
                    dvs_d     = dvs_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                rem_d = q_bit ? rem_diff : rem_shift;
                acc_d = {acc_q[DW-2:0], q_bit};
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StFix: begin
                if (dvs_q == '0) begin
                    quo_res_d = neg_dvd_q ? MinNeg : MaxPos;
                    rem_res_d = dvd_q;
                    ovf_d     = 1'b0;
                    dbz_d     = 1'b1;
                end else begin
                    // A non-negative quotient with its MSB set only arises from MIN / -1.
                    quo_res_d = q_signed;
                    rem_res_d = r_signed;
                    ovf_d     = ~q_neg & acc_q[DW-1];
                    dbz_d     = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            quo_res_q <= '0;
            rem_res_q <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            dvd_q     <= dvd_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            quo_res_q <= quo_res_d;
            rem_res_q <= rem_res_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.out_valid   = (state_q == StDone);
    assign bus.quotient    = quo_res_q;
    assign bus.remainder   = rem_res_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the operand and result width in bits; legal values are multiples of 4, at least 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: dividend/divisor present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port dividend, input signed, DATA_WIDTH bits: two's complement numerator.
REQ-007 SHALL have port divisor, input signed, DATA_WIDTH bits: two's complement denominator.
REQ-008 SHALL have port out_valid, output, 1 bit: results valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts results.
REQ-010 SHALL have port quotient, output, DATA_WIDTH bits: signed quotient.
REQ-011 SHALL have port remainder, output, DATA_WIDTH bits: signed remainder.
REQ-012 SHALL have port overflow, output, 1 bit: quotient not representable.
REQ-013 SHALL have port div_by_zero, output, 1 bit: divisor was zero.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-016 Accept SHALL occur on an edge with in_valid=1 in IDLE: latch operand signs and magnitudes, clear partial remainder, iteration counter := 0, IDLE->CALC.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle on magnitudes (DATA_WIDTH+1-bit partial remainder), one quotient bit per step, MSB first; after DATA_WIDTH steps CALC->FIX.
REQ-018 FIX SHALL apply signs and register quotient, remainder and flags, then go FIX->DONE.
REQ-019 Latency SHALL be fixed: out_valid high exactly DATA_WIDTH+1 clock edges after the accept edge, for all operands including the error cases.
REQ-020 Rounding SHALL truncate toward zero; the remainder takes the sign of the dividend; dividend = quotient*divisor + remainder whenever both flags are 0.
REQ-021 divisor=0 SHALL give div_by_zero=1, overflow=0, quotient = max positive if dividend>=0 else most negative, and remainder=dividend.
REQ-022 dividend = most negative and divisor = -1 SHALL give overflow=1, quotient = most negative (wrapped), and remainder=0.
REQ-023 Operands SHALL be sampled only at accept; later changes to dividend or divisor are ignored until the next accept.
REQ-024 DONE SHALL hold out_valid and all result outputs stable until an edge with out_ready=1, then go DONE->IDLE; out_valid falls on that edge.
REQ-025 in_ready SHALL be 0 in DONE even while out_ready=1; a new accept is possible no earlier than the edge after DONE->IDLE.
REQ-026 in_valid in CALC, FIX or DONE SHALL be ignored: no state change, no queuing.
REQ-027 Result outputs SHALL retain their last values in IDLE and CALC and change only at FIX->DONE.

Reset
REQ-028 rst=1 on an edge SHALL force IDLE from any state, aborting any operation in progress with no result produced.
REQ-029 Reset values SHALL be: in_ready=1, out_valid=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, counter=0.
REQ-030 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification (DATA_WIDTH=16)
REQ-031 Basic division: 100 / 7 accepted, out_ready=1 -> out_valid 17 edges after accept, quotient=14, remainder=2, both flags 0.
REQ-032 Signed cases: -100/7 -> quotient=-14, remainder=-2; 100/-7 -> quotient=-14, remainder=2; -100/-7 -> quotient=14, remainder=-2.
REQ-033 Error cases: 1234/0 -> quotient=0x7FFF, remainder=1234, div_by_zero=1; -32768/-1 -> quotient=0x8000, remainder=0, overflow=1; both after 17 edges.
REQ-034 Back-pressure: out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; out_ready=1 -> next edge IDLE and in_ready=1.
REQ-035 Reset mid-operation: rst pulsed at iteration 8 of 7/2 -> next cycle IDLE with all outputs at reset values; a new 9/3 then yields quotient=3, remainder=0.
REQ-036 Random regression: 10k random signed operand pairs, randomized in_valid/out_ready gaps -> every result matches REQ-020 to REQ-022 and latency is always 17.
